// File: rtl/axi_pkt_arb_pkg.sv
// Shared types and helpers for the round-robin packet arbiter family.
package axi_pkt_arb_pkg;

  // Widest requester vector any arbiter in this family supports.
  localparam int ARB_MAX_INPUTS = 16;
  localparam int ARB_IDX_W      = $clog2(ARB_MAX_INPUTS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    ABORT = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  // First requester strictly after 'last', cyclically over n inputs.
  // Scanning from the farthest offset down lets the nearest one win; offset n
  // is 'last' itself, so a lone requester can be re-granted.
  function automatic logic [ARB_IDX_W-1:0] rr_next(
    input logic [ARB_MAX_INPUTS-1:0] req,
    input logic [ARB_IDX_W-1:0]      last,
    input int                        n
  );
    int idx;
    rr_next = last;
    for (int i = ARB_MAX_INPUTS; i >= 1; i--) begin
      if (i <= n) begin
        idx = (int'(last) + i) % n;
        if (req[idx]) rr_next = ARB_IDX_W'(idx);
      end
    end
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// Combinational round-robin priority encoder, shared by several arbiters.
module rr_prio_enc
  import axi_pkt_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int GW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] last,
  output logic [GW-1:0] grant,
  output logic          found
);

  logic [ARB_MAX_INPUTS-1:0] req_ext;
  logic [ARB_IDX_W-1:0]      last_ext;

  // Widen to the package helper's fixed-size arguments.
  assign req_ext  = ARB_MAX_INPUTS'(req);
  assign last_ext = ARB_IDX_W'(last);

  // Next index after last_grant among active requests.
  assign grant = GW'(rr_next(req_ext, last_ext, N));
  assign found = |req;

endmodule

// File: rtl/axi_pkt_arb_rr.sv
// Packet-atomic round-robin AXI-Stream arbiter.
// Define AXI_PKT_ARB_WATCHDOG_EN to enable the mid-packet stall watchdog.
//
// state | meaning
// IDLE  | no packet in flight; arbitration bubble, picks next requester
// PASS  | granted input passed straight through until its tlast beat
// ABORT | watchdog fired; emitting a forced tlast+terror tail beat
// DRAIN | swallowing the rest of the hung packet until its tlast
module axi_pkt_arb_rr
  import axi_pkt_arb_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 4,
  parameter int TIMEOUT    = 256
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            clear,
  input  logic [NUM_INPUTS*WIDTH-1:0]     i_tdata,
  input  logic [NUM_INPUTS-1:0]           i_tvalid,
  input  logic [NUM_INPUTS-1:0]           i_tlast,
  input  logic [NUM_INPUTS-1:0]           i_terror,
  output logic [NUM_INPUTS-1:0]           i_tready,
  output logic [WIDTH-1:0]                o_tdata,
  output logic                            o_tvalid,
  output logic                            o_tlast,
  output logic                            o_terror,
  input  logic                            o_tready,
  output logic [$clog2(NUM_INPUTS)-1:0]   o_grant,
  output logic                            o_active,
  output logic                            o_abort
);

  localparam int GW = $clog2(NUM_INPUTS);

  if (NUM_INPUTS < 2 || NUM_INPUTS > ARB_MAX_INPUTS || TIMEOUT < 2) begin : g_param_check
    $error("axi_pkt_arb_rr: parameter out of range");
  end

  arb_state_t    state;
  logic [GW-1:0] grant;
  logic [GW-1:0] last_grant;
  logic [GW-1:0] next_grant;
  logic          found;
  logic          g_valid;
  logic          g_last;

  rr_prio_enc #(
    .N  (NUM_INPUTS),
    .GW (GW)
  ) u_enc (
    .req   (i_tvalid),
    .last  (last_grant),
    .grant (next_grant),
    .found (found)
  );

  assign g_valid  = i_tvalid[grant];
  assign g_last   = i_tlast[grant];
  assign o_grant  = grant;
  assign o_active = (state != IDLE);

`ifdef AXI_PKT_ARB_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] stall_cnt;
  logic          abort_q;
  assign o_abort = abort_q;
`else
  assign o_abort = 1'b0;
`endif

  // Arbitration FSM, grant registers and stall watchdog.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_INPUTS - 1);
`ifdef AXI_PKT_ARB_WATCHDOG_EN
      stall_cnt  <= '0;
      abort_q    <= 1'b0;
`endif
    end else if (clear) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= GW'(NUM_INPUTS - 1);
`ifdef AXI_PKT_ARB_WATCHDOG_EN
      stall_cnt  <= '0;
      abort_q    <= 1'b0;
`endif
    end else begin
`ifdef AXI_PKT_ARB_WATCHDOG_EN
      abort_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef AXI_PKT_ARB_WATCHDOG_EN
          stall_cnt <= '0;
`endif
          if (found) begin
            grant      <= next_grant;
            last_grant <= next_grant;
            state      <= PASS;
          end
        end
        PASS: begin
          if (g_valid && o_tready && g_last) state <= IDLE;
`ifdef AXI_PKT_ARB_WATCHDOG_EN
          if (g_valid) begin
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
            if (stall_cnt == CW'(TIMEOUT - 1)) begin
              abort_q <= 1'b1;
              state   <= ABORT;
            end
          end
`endif
        end
`ifdef AXI_PKT_ARB_WATCHDOG_EN
        ABORT: begin
          stall_cnt <= '0;
          if (o_tready) state <= DRAIN;
        end
        DRAIN: begin
          if (g_valid && g_last) state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Output mux: zero-latency passthrough in PASS, forced tail in ABORT.
  always_comb begin
    o_tdata  = '0;
    o_tvalid = 1'b0;
    o_tlast  = 1'b0;
    o_terror = 1'b0;
    i_tready = '0;
    case (state)
      PASS: begin
        o_tdata         = i_tdata[grant*WIDTH +: WIDTH];
        o_tvalid        = g_valid;
        o_tlast         = g_last;
        o_terror        = i_terror[grant];
        i_tready[grant] = o_tready;
      end
`ifdef AXI_PKT_ARB_WATCHDOG_EN
      ABORT: begin
        o_tvalid = 1'b1;
        o_tlast  = 1'b1;
        o_terror = 1'b1;
      end
      DRAIN: begin
        i_tready[grant] = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_pkt_arb_rr.sv
// Directed testbench for axi_pkt_arb_rr (NUM_INPUTS=4, WIDTH=32, TIMEOUT=16).
// Expectations for the stall test follow AXI_PKT_ARB_WATCHDOG_EN.
module tb_axi_pkt_arb_rr;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int TO = 16;
  localparam int MAXB = 64;

  logic           clk = 1'b0;
  logic           reset_n;
  logic           clear;
  logic [N*W-1:0] i_tdata;
  logic [N-1:0]   i_tvalid, i_tlast, i_terror, i_tready;
  logic [W-1:0]   o_tdata;
  logic           o_tvalid, o_tlast, o_terror, o_tready;
  logic [1:0]     o_grant;
  logic           o_active, o_abort;

  always #5 clk = ~clk;

  axi_pkt_arb_rr #(.WIDTH(W), .NUM_INPUTS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tlast(i_tlast), .i_terror(i_terror),
    .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tlast(o_tlast), .o_terror(o_terror),
    .o_tready(o_tready),
    .o_grant(o_grant), .o_active(o_active), .o_abort(o_abort)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-input beat sources
  logic [31:0] s_data [N][MAXB];
  logic        s_last [N][MAXB];
  logic        s_err  [N][MAXB];
  int          s_cnt [N];
  int          s_ptr [N];
  int          s_stall_at [N];
  int          s_stall_len [N];
  bit          rand_ready;

  typedef struct {
    logic [31:0] d;
    logic        l;
    logic        e;
    logic [1:0]  g;
    int          c;
  } beat_t;

  beat_t obeats[$];
  int    cyc;
  int    abort_cnt, abort_cyc;
  logic  snap_active, snap_tvalid;
  logic [1:0] snap_grant;

  function automatic logic [31:0] mk(input int n, input int p, input int b);
    return {8'(n), 8'h80, 8'(p), 8'(b)};
  endfunction

  task automatic add_pkt(input int n, input int p, input int len, input bit err_last);
    for (int b = 0; b < len; b++) begin
      s_data[n][s_cnt[n]] = mk(n, p, b);
      s_last[n][s_cnt[n]] = (b == len - 1);
      s_err[n][s_cnt[n]]  = err_last && (b == len - 1);
      s_cnt[n]++;
    end
  endtask

  task automatic drive_inputs();
    for (int n = 0; n < N; n++) begin
      int p;
      p = s_ptr[n];
      i_tvalid[n] = (p < s_cnt[n]) && !(p == s_stall_at[n] && s_stall_len[n] > 0);
      if (p < MAXB) begin
        i_tdata[n*W +: W] = s_data[n][p];
        i_tlast[n]        = s_last[n][p];
        i_terror[n]       = s_err[n][p];
      end
    end
  endtask

  function automatic bit all_done();
    for (int n = 0; n < N; n++) if (s_ptr[n] < s_cnt[n]) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: sample at negedge, update stimulus just after posedge.
  task automatic cycle();
    logic [N-1:0] fire;
    beat_t bt;
    @(negedge clk);
    fire = i_tvalid & i_tready;
    if (o_tvalid && o_tready) begin
      bt.d = o_tdata; bt.l = o_tlast; bt.e = o_terror; bt.g = o_grant; bt.c = cyc;
      obeats.push_back(bt);
    end
    if (o_abort) begin
      abort_cnt++;
      abort_cyc = cyc;
    end
    snap_active = o_active;
    snap_tvalid = o_tvalid;
    snap_grant  = o_grant;
    @(posedge clk);
    #1;
    cyc++;
    for (int n = 0; n < N; n++) begin
      if (s_ptr[n] == s_stall_at[n] && s_stall_len[n] > 0) s_stall_len[n]--;
      if (fire[n]) s_ptr[n]++;
    end
    if (rand_ready) o_tready = 1'($urandom_range(0, 1));
    drive_inputs();
  endtask

  task automatic clear_sources();
    for (int n = 0; n < N; n++) begin
      s_cnt[n] = 0; s_ptr[n] = 0; s_stall_at[n] = -1; s_stall_len[n] = 0;
      for (int b = 0; b < MAXB; b++) begin
        s_data[n][b] = '0; s_last[n][b] = 1'b0; s_err[n][b] = 1'b0;
      end
    end
    obeats.delete();
    abort_cnt = 0; abort_cyc = -1;
  endtask

  task automatic tb_reset();
    reset_n = 1'b0; clear = 1'b0; o_tready = 1'b1; rand_ready = 1'b0;
    clear_sources();
    drive_inputs();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic run_until_done(input int budget, input int tail);
    int k;
    k = 0;
    while (!all_done() && k < budget) begin
      cycle();
      k++;
    end
    check_eq("done_within_budget", 64'(all_done()), 64'd1);
    repeat (tail) cycle();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc = 0;
    i_tdata = '0; i_tvalid = '0; i_tlast = '0; i_terror = '0;

    // Reset with every input requesting
    reset_n = 1'b0; clear = 1'b0; o_tready = 1'b1; rand_ready = 1'b0;
    clear_sources();
    for (int n = 0; n < N; n++) add_pkt(n, 0, 2, 1'b0);
    drive_inputs();
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("rst_o_tvalid", 64'(o_tvalid), 64'd0);
    check_eq("rst_o_tlast",  64'(o_tlast),  64'd0);
    check_eq("rst_o_terror", 64'(o_terror), 64'd0);
    check_eq("rst_o_tdata",  64'(o_tdata),  64'd0);
    check_eq("rst_i_tready", 64'(i_tready), 64'd0);
    check_eq("rst_o_active", 64'(o_active), 64'd0);
    check_eq("rst_o_abort",  64'(o_abort),  64'd0);
    check_eq("rst_o_grant",  64'(o_grant),  64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check_eq("rel_idle_active", 64'(o_active), 64'd0);
    check_eq("rel_idle_tvalid", 64'(o_tvalid), 64'd0);
    @(negedge clk);
    check_eq("first_grant",  64'(o_grant),  64'd0);
    check_eq("first_active", 64'(o_active), 64'd1);
    check_eq("first_tready", 64'(i_tready), 64'b0001);

    // Fairness: three 8-beat packets per input, sink always ready
    tb_reset();
    for (int p = 0; p < 3; p++)
      for (int n = 0; n < N; n++) add_pkt(n, p, 8, 1'b0);
    drive_inputs();
    run_until_done(400, 3);
    check_eq("rr_beat_count", 64'(obeats.size()), 64'd96);
    if (obeats.size() == 96) begin
      for (int k = 0; k < 12; k++) begin
        check_eq("rr_grant", 64'(obeats[k*8].g), 64'(k % 4));
        for (int b = 0; b < 8; b++)
          check_eq("rr_data", 64'(obeats[k*8+b].d), 64'(mk(k % 4, k / 4, b)));
        check_eq("rr_tlast", 64'(obeats[k*8+7].l), 64'd1);
        check_eq("rr_in_pkt_span", 64'(obeats[k*8+7].c - obeats[k*8].c), 64'd7);
        if (k > 0)
          check_eq("rr_bubble", 64'(obeats[k*8].c - obeats[k*8-1].c), 64'd2);
      end
    end

    // Error forwarding into a packet gate that drops errored packets
    tb_reset();
    add_pkt(0, 0, 4, 1'b0);
    add_pkt(1, 0, 4, 1'b0);
    add_pkt(2, 0, 4, 1'b1);
    drive_inputs();
    run_until_done(200, 3);
    begin
      int delivered[$];
      int err_beats;
      bit pkt_err;
      logic [31:0] first_d;
      bit first;
      pkt_err = 1'b0; first = 1'b1; err_beats = 0; first_d = '0;
      foreach (obeats[i]) begin
        if (first) first_d = obeats[i].d;
        first = 1'b0;
        if (obeats[i].e) begin
          err_beats++;
          check_eq("err_from_input2", 64'(obeats[i].g), 64'd2);
        end
        pkt_err = pkt_err | obeats[i].e;
        if (obeats[i].l) begin
          if (!pkt_err) delivered.push_back(int'(first_d[31:24]));
          pkt_err = 1'b0;
          first = 1'b1;
        end
      end
      check_eq("gate_beats_total", 64'(obeats.size()), 64'd12);
      check_eq("gate_err_beats", 64'(err_beats), 64'd1);
      check_eq("gate_pkt_count", 64'(delivered.size()), 64'd2);
      if (delivered.size() == 2) begin
        check_eq("gate_pkt0_src", 64'(delivered[0]), 64'd0);
        check_eq("gate_pkt1_src", 64'(delivered[1]), 64'd1);
      end
    end

    // Single-beat packets on inputs 1 and 3 with random backpressure
    tb_reset();
    for (int p = 0; p < 6; p++) begin
      add_pkt(1, p, 1, 1'b0);
      add_pkt(3, p, 1, 1'b0);
    end
    rand_ready = 1'b1;
    drive_inputs();
    run_until_done(400, 3);
    rand_ready = 1'b0;
    o_tready = 1'b1;
    check_eq("sb_beat_count", 64'(obeats.size()), 64'd12);
    if (obeats.size() == 12) begin
      for (int k = 0; k < 12; k++) begin
        int n;
        n = (k % 2 == 0) ? 1 : 3;
        check_eq("sb_data",  64'(obeats[k].d), 64'(mk(n, k / 2, 0)));
        check_eq("sb_tlast", 64'(obeats[k].l), 64'd1);
        check_eq("sb_grant", 64'(obeats[k].g), 64'(n));
      end
    end

    // Mid-packet stall on input 0 after 5 beats, input 1 waiting
    tb_reset();
    add_pkt(0, 0, 10, 1'b0);
    add_pkt(1, 0, 2, 1'b0);
    s_stall_at[0] = 5;
`ifdef AXI_PKT_ARB_WATCHDOG_EN
    s_stall_len[0] = 20;
`else
    s_stall_len[0] = 40;
`endif
    drive_inputs();
    run_until_done(300, 4);
`ifdef AXI_PKT_ARB_WATCHDOG_EN
    check_eq("wd_beat_count", 64'(obeats.size()), 64'd8);
    check_eq("wd_abort_pulses", 64'(abort_cnt), 64'd1);
    check_eq("wd_drained", 64'(s_ptr[0]), 64'd10);
    if (obeats.size() == 8) begin
      for (int b = 0; b < 5; b++)
        check_eq("wd_pre_data", 64'(obeats[b].d), 64'(mk(0, 0, b)));
      check_eq("wd_abort_delay", 64'(abort_cyc - obeats[4].c), 64'd17);
      check_eq("wd_tail_cycle", 64'(obeats[5].c), 64'(abort_cyc));
      check_eq("wd_tail_data",  64'(obeats[5].d), 64'd0);
      check_eq("wd_tail_last",  64'(obeats[5].l), 64'd1);
      check_eq("wd_tail_err",   64'(obeats[5].e), 64'd1);
      check_eq("wd_next_grant", 64'(obeats[6].g), 64'd1);
      check_eq("wd_next_data0", 64'(obeats[6].d), 64'(mk(1, 0, 0)));
      check_eq("wd_next_data1", 64'(obeats[7].d), 64'(mk(1, 0, 1)));
    end
`else
    check_eq("stall_beat_count", 64'(obeats.size()), 64'd12);
    check_eq("stall_no_abort", 64'(abort_cnt), 64'd0);
    if (obeats.size() == 12) begin
      for (int b = 0; b < 10; b++) begin
        check_eq("stall_data",  64'(obeats[b].d), 64'(mk(0, 0, b)));
        check_eq("stall_grant", 64'(obeats[b].g), 64'd0);
      end
      check_eq("stall_gap", 64'(obeats[5].c - obeats[4].c), 64'd41);
      check_eq("stall_next_grant", 64'(obeats[10].g), 64'd1);
    end
`endif

    // Synchronous clear at beat 3 of a 10-beat packet
    tb_reset();
    add_pkt(0, 0, 10, 1'b0);
    add_pkt(1, 0, 2, 1'b0);
    drive_inputs();
    begin
      int k;
      k = 0;
      while (obeats.size() < 2 && k < 50) begin
        cycle();
        k++;
      end
      check_eq("clr_reach_beat3", 64'(obeats.size()), 64'd2);
    end
    clear = 1'b1;
    cycle();
    clear = 1'b0;
    cycle();
    check_eq("clr_idle_active", 64'(snap_active), 64'd0);
    check_eq("clr_idle_tvalid", 64'(snap_tvalid), 64'd0);
    cycle();
    check_eq("clr_regrant_0", 64'(snap_grant), 64'd0);
    check_eq("clr_regrant_active", 64'(snap_active), 64'd1);
    run_until_done(200, 3);
    check_eq("clr_beat_count", 64'(obeats.size()), 64'd12);
    if (obeats.size() == 12) begin
      check_eq("clr_beat3_data", 64'(obeats[3].d), 64'(mk(0, 0, 3)));
      check_eq("clr_bubble", 64'(obeats[3].c - obeats[2].c), 64'd2);
      check_eq("clr_then_input1", 64'(obeats[10].g), 64'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_pkt_arb_rr.md
# axi_pkt_arb_rr

Round-robin, packet-atomic arbiter that shares one downstream `axi_packet_gate` (or any AXI-Stream packet sink) among `NUM_INPUTS` AXI-Stream requesters. Grant is held for a whole packet and advances only after `tlast`. Each input's `terror` is forwarded per beat, so the downstream gate drops bad packets. An optional stall watchdog aborts a hung packet by forcing an error-terminated tail, so the gate discards it.

## Interface
- `WIDTH`, 32, data width per stream.
- `NUM_INPUTS`, 4, number of requesters, 2..16.
- `TIMEOUT`, 256, consecutive mid-packet stall cycles before abort; only used with the watchdog macro; ≥2.
- `clk` in 1 — single clock, all logic.
- `reset_n` in 1 — asynchronous, active-low reset.
- `clear` in 1 — synchronous; returns the arbiter to its reset state.
- `i_tdata` in NUM_INPUTS*WIDTH — input n occupies bits [n*WIDTH +: WIDTH].
- `i_tvalid`, `i_tlast`, `i_terror` in NUM_INPUTS — per-input flags.
- `i_tready` out NUM_INPUTS — per-input ready.
- `o_tdata` out WIDTH, `o_tvalid` out 1, `o_tlast` out 1, `o_terror` out 1 — output stream.
- `o_tready` in 1 — output ready.
- `o_grant` out $clog2(NUM_INPUTS) — index of the current or last-granted input.
- `o_active` out 1 — a packet is in progress (state ≠ IDLE).
- `o_abort` out 1 — one-cycle pulse when the watchdog fires; tied 0 without the macro.

## Operation
- States: IDLE, PASS, ABORT, DRAIN. ABORT and DRAIN exist only with the watchdog macro.
- IDLE
  - All `i_tready`=0, `o_tvalid`=0.
  - If any `i_tvalid` is set, pick the first requester strictly after `last_grant`, cyclically.
  - Register it into `o_grant` and `last_grant`, then go to PASS.
- PASS
  - Combinational passthrough of the granted input g: `o_tdata`/`o_tlast`/`o_terror` = input g, `o_tvalid`=`i_tvalid[g]`, `i_tready[g]`=`o_tready`.
  - All other `i_tready` are 0.
  - A beat with `i_tvalid[g]`, `o_tready` and `i_tlast[g]` all set moves to IDLE.
- Outside PASS, `o_tdata`, `o_tlast` and `o_terror` are driven to 0.
- Requests from non-granted inputs are ignored mid-packet; no preemption.
- Single-beat packets (tlast on the first beat) are legal.
- `clear` overrides everything: state goes to IDLE and `last_grant` to NUM_INPUTS-1. The user guarantees downstream is cleared together with the arbiter.
- Reset values: state IDLE, `last_grant`=NUM_INPUTS-1 (input 0 wins first), `o_grant`=0, `o_tvalid`=0, `o_tlast`=0, `o_terror`=0, `o_tdata`=0, `i_tready`=0, `o_active`=0, `o_abort`=0, stall counter 0.
- Reset asserted mid-packet: immediate return to the reset state; the partial packet is abandoned.

## Timing
- Zero-latency datapath in PASS; full throughput, one beat per cycle, within a packet.
- One-cycle arbitration bubble after every packet: the IDLE cycle carries no output beat.
- Back-to-back packets from N busy inputs therefore cost one dead cycle each.
- Grant latency: a request in IDLE at cycle t is granted at t+1, and its first beat can transfer at t+1.
- Fairness: with all inputs continuously requesting, grants go 0,1,2,…,N-1,0,…
- Wrap: `last_grant`=N-1 selects input 0 first.
- Simultaneous tlast-accept and new requests: the next grant is computed in the following IDLE cycle using the updated `last_grant`.

## Configuration
- `AXI_PKT_ARB_WATCHDOG_EN` defined — watchdog enabled:
  - In PASS, the stall counter increments each cycle with `i_tvalid[g]`=0 and resets on any cycle with `i_tvalid[g]`=1.
  - When the counter reaches TIMEOUT: pulse `o_abort` and go to ABORT.
  - ABORT drives `o_tvalid`=1, `o_tlast`=1, `o_terror`=1, `o_tdata`=0, held until `o_tready`. It then goes to DRAIN.
  - DRAIN drives `i_tready[g]`=1 and `o_tvalid`=0, discarding beats until `i_tlast[g]` is accepted, then goes to IDLE.
  - Counter width is $clog2(TIMEOUT+1).
- Undefined: states ABORT/DRAIN, the counter and `TIMEOUT` logic are absent, `o_abort`=0, and stalls wait forever.

## Structure
- Package `axi_pkt_arb_pkg`:
  - state enum `arb_state_t` {IDLE, PASS, ABORT, DRAIN};
  - function `rr_next(req, last)` returning the next index;
  - localparam for the grant width.
- Sub-module `rr_prio_enc` (combinational): inputs are the request vector and `last_grant`; outputs are the grant index and `found`. It is reused by other arbiters.
- The top level holds the FSM, grant registers, watchdog counter and datapath mux.

## Test plan
Defaults for all tests are NUM_INPUTS=4, WIDTH=32, TIMEOUT=16.
- Reset: hold `reset_n`=0 for 10 cycles → all outputs 0; release → `o_grant`=0, state IDLE.
- All 4 inputs each send three 8-beat packets, sink always ready → grant order 0,1,2,3,0,…; packets never interleave; exactly one bubble between packets; data intact.
- Input 2 sends a packet with `terror`=1 on its last beat, while 0 and 1 send clean packets; the arbiter feeds `axi_packet_gate` → the gate output contains only the packets from 0 and 1.
- Single-beat packets on inputs 1 and 3 with random `o_tready` (50%) → each beat has tlast; grant alternates 1,3; no beat is lost.
- Watchdog: input 0 sends 5 beats then drops `tvalid` for 20 cycles → `o_abort` pulses 16 cycles after the stall begins; one beat with tlast=1, terror=1, data=0 follows; the remaining input 0 beats are drained; input 1 is granted next.
- `clear` pulsed at beat 3 of a 10-beat packet → next cycle state is IDLE, `o_active`=0, `last_grant` reset so input 0 wins the next arbitration.
